axis_reg_pipe: RTL and testbench
================================

Name: axis_reg_pipe

Overview:
- Parametrised AXI4-Stream register pipeline: a chain of STAGES register slices between a slave and a master stream, used to break timing across SLR and long-route boundaries.
- Each slice runs in one of three modes: bypass, half-rate or full-rate skid.
- Carries optional TID/TDEST/TUSER sidebands and reports the number of beats held, for backpressure debug and credit logic.

Parameters:
- DATA_BITS, 512, TDATA width; multiple of 8; TKEEP width is DATA_BITS/8.
- ID_BITS, 0, TID width; 0 removes the field (port tied to 1 bit, ignored/driven 0).
- DEST_BITS, 0, TDEST width; same 0 rule.
- USER_BITS, 0, TUSER width; same 0 rule.
- STAGES, 2, number of chained slices; range 1..8.
- REG_MODE, 2, slice mode for every stage: 0 bypass (wires), 1 half-rate, 2 full-rate skid.

Ports:
- aclk  in  1  clock
- areset  in  1  synchronous active-high reset
- s_axis_tvalid/tready  in/out  1  slave handshake
- s_axis_tdata  in  DATA_BITS  payload
- s_axis_tkeep  in  DATA_BITS/8  byte enables
- s_axis_tlast  in  1  end of packet
- s_axis_tid/tdest/tuser  in  max(1,ID_BITS)/max(1,DEST_BITS)/max(1,USER_BITS)  sidebands
- m_axis_*  out (tready in)  same widths  master side
- occupancy  out  $clog2(2*STAGES+1)  beats held across all slices

Behaviour:
- One clock (aclk). Reset is synchronous and active-high (areset).
- Beat fields are {tdata, tkeep, tlast, tid, tdest, tuser}. They propagate as one unit and are never reordered, dropped or duplicated.
- Reset, all modes:
  - every slice valid flag = 0; every registered tready = 0.
  - m_axis_tvalid = 0; m_axis payload outputs = 0; occupancy = 0.
  - Reset mid-operation discards all held beats, even with tvalid high.
- REG_MODE 0:
  - m_axis_* = s_axis_*; s_axis_tready = m_axis_tready; occupancy = 0.
  - Latency 0; STAGES is ignored.
- REG_MODE 1 (per slice; one output register, no skid):
  - tready_out = !out_valid, registered.
  - Input handshake loads the register. Output handshake clears out_valid.
  - No combinational path from m tready to s tready.
  - Latency 1 cycle per slice; throughput 1 beat / 2 cycles.
- REG_MODE 2 (per slice; output register plus skid register):
  - tready_next = down_ready || (!skid_valid && (!out_valid || !up_valid)); tready is registered.
  - Accept while tready=1:
    - if down_ready || !out_valid, the beat goes to the output register;
    - otherwise it goes to skid.
  - When tready=0 and down_ready: skid moves to output, skid_valid=0.
  - Latency 1 cycle per slice; 1 beat/cycle sustained. Absorbs one extra beat after downstream deasserts ready.
  - s_axis_tready first rises one cycle after areset falls.
- Chaining:
  - total latency with an idle pipe = STAGES cycles (mode 1 and 2);
  - capacity = STAGES (mode 1) or 2*STAGES (mode 2).
- occupancy:
  - registered sum of all slice valid flags;
  - updated every cycle, reflects the state after the current edge;
  - saturates naturally at capacity; never exceeds it.
- Simultaneous input and output handshake on a full mode-2 slice: illegal by construction (tready=0). On a non-full slice, both complete in the same cycle and occupancy is unchanged.
- AXIS rules:
  - m_axis_tvalid never drops and payload never changes while m_axis_tvalid && !m_axis_tready.
  - s_axis_tvalid/data ignored while s_axis_tready=0.

Test Plan:
- Reset, then REG_MODE=2, STAGES=2, m ready=1, beats data=0x1..0x10 back-to-back -> first m beat 2 cycles after the first s handshake; 16 beats in order; one beat every cycle; occupancy peaks at 2.
- REG_MODE=2, STAGES=3: m ready held 0 and s driven continuously -> exactly 6 beats accepted; s tready=0 and occupancy=6 thereafter; release ready -> 6 beats out in order, none lost.
- REG_MODE=1, STAGES=1, continuous s valid, m ready=1, 20 beats -> s tready toggles 1/0; 20 beats out over 40 cycles; tlast only on beat 20.
- Random valid/ready at 50% each, REG_MODE=2, STAGES=4, ID/DEST/USER_BITS=4/3/8, 1000 beats -> scoreboard match including sidebands; AXIS stability checker passes.
- Assert areset for 1 cycle with 5 beats held (REG_MODE=2, STAGES=4) -> next cycle m tvalid=0 and occupancy=0; s tready=1 one cycle after areset falls; the next beat is fresh.
- REG_MODE=0 -> m ports equal s ports combinationally every cycle; occupancy stays 0.

Source files
------------

// File: rtl/axis_reg_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : axis_reg_pipe
//  Description : AXI4-Stream register pipeline. STAGES chained slices, each
//                bypass (wires), half-rate (single output register) or
//                full-rate (output register plus skid register). Carries
//                optional TID/TDEST/TUSER sidebands and reports the number
//                of beats currently held.
//  Ports       : aclk, areset (sync, active-high)
//                s_axis_* : slave stream (tvalid/tready/tdata/tkeep/tlast/
//                           tid/tdest/tuser)
//                m_axis_* : master stream, same fields
//                occupancy: beats held across all slices (registered)
//  Revision    : 1.0 - initial release
// ============================================================================
module axis_reg_pipe #(
    parameter int DATA_BITS = 512,
    parameter int ID_BITS   = 0,
    parameter int DEST_BITS = 0,
    parameter int USER_BITS = 0,
    parameter int STAGES    = 2,
    parameter int REG_MODE  = 2,
    localparam int c_KEEP_W = DATA_BITS / 8,
    localparam int c_ID_W   = (ID_BITS   > 0) ? ID_BITS   : 1,
    localparam int c_DEST_W = (DEST_BITS > 0) ? DEST_BITS : 1,
    localparam int c_USER_W = (USER_BITS > 0) ? USER_BITS : 1,
    localparam int c_OCC_W  = $clog2(2 * STAGES + 1)
) (
    input  logic                 aclk,
    input  logic                 areset,

    input  logic                 s_axis_tvalid,
    output logic                 s_axis_tready,
    input  logic [DATA_BITS-1:0] s_axis_tdata,
    input  logic [c_KEEP_W-1:0]  s_axis_tkeep,
    input  logic                 s_axis_tlast,
    input  logic [c_ID_W-1:0]    s_axis_tid,
    input  logic [c_DEST_W-1:0]  s_axis_tdest,
    input  logic [c_USER_W-1:0]  s_axis_tuser,

    output logic                 m_axis_tvalid,
    input  logic                 m_axis_tready,
    output logic [DATA_BITS-1:0] m_axis_tdata,
    output logic [c_KEEP_W-1:0]  m_axis_tkeep,
    output logic                 m_axis_tlast,
    output logic [c_ID_W-1:0]    m_axis_tid,
    output logic [c_DEST_W-1:0]  m_axis_tdest,
    output logic [c_USER_W-1:0]  m_axis_tuser,

    output logic [c_OCC_W-1:0]   occupancy
);

    localparam int c_BEAT_W = DATA_BITS + c_KEEP_W + 1 + c_ID_W + c_DEST_W + c_USER_W;

    // Absent sideband fields are forced to zero at the input so every slice
    // register (and therefore the master port) carries 0 for them.
    logic [c_ID_W-1:0]   w_s_id;
    logic [c_DEST_W-1:0] w_s_dest;
    logic [c_USER_W-1:0] w_s_user;
    logic [c_BEAT_W-1:0] w_s_beat;
    logic [c_BEAT_W-1:0] w_m_beat;

    assign w_s_id   = (ID_BITS   > 0) ? s_axis_tid   : '0;
    assign w_s_dest = (DEST_BITS > 0) ? s_axis_tdest : '0;
    assign w_s_user = (USER_BITS > 0) ? s_axis_tuser : '0;
    assign w_s_beat = {s_axis_tdata, s_axis_tkeep, s_axis_tlast, w_s_id, w_s_dest, w_s_user};

    assign {m_axis_tdata, m_axis_tkeep, m_axis_tlast,
            m_axis_tid, m_axis_tdest, m_axis_tuser} = w_m_beat;

    if (REG_MODE == 0) begin : g_bypass
        assign w_m_beat      = w_s_beat;
        assign m_axis_tvalid = s_axis_tvalid;
        assign s_axis_tready = m_axis_tready;
        assign occupancy     = '0;
    end else begin : g_pipe
        // Index i is the upstream side of slice i; index STAGES is the master.
        logic [c_BEAT_W-1:0] w_data  [STAGES+1];
        logic                w_valid [STAGES+1];
        logic                w_ready [STAGES+1];
        logic [1:0]          w_cnt_nxt [STAGES];
        logic [c_OCC_W-1:0]  w_occ_nxt;
        logic [c_OCC_W-1:0]  r_occ;

        assign w_data[0]       = w_s_beat;
        assign w_valid[0]      = s_axis_tvalid;
        assign s_axis_tready   = w_ready[0];
        assign w_ready[STAGES] = m_axis_tready;
        assign w_m_beat        = w_data[STAGES];
        assign m_axis_tvalid   = w_valid[STAGES];

        for (genvar i = 0; i < STAGES; i++) begin : g_stage
            if (REG_MODE == 1) begin : g_half
                logic                r_out_valid;
                logic                r_ready;
                logic [c_BEAT_W-1:0] r_out_data;
                logic                w_in_hs;
                logic                w_out_hs;
                logic                w_out_nxt;

                assign w_in_hs  = w_valid[i] && r_ready;
                assign w_out_hs = r_out_valid && w_ready[i+1];

                always_comb begin
                    w_out_nxt = r_out_valid;
                    if (w_in_hs) begin
                        w_out_nxt = 1'b1;
                    end else if (w_out_hs) begin
                        w_out_nxt = 1'b0;
                    end
                end

                always_ff @(posedge aclk) begin
                    if (areset) begin
                        r_out_valid <= 1'b0;
                        r_ready     <= 1'b0;
                        r_out_data  <= '0;
                    end else begin
                        r_out_valid <= w_out_nxt;
                        r_ready     <= !w_out_nxt;
                        if (w_in_hs) begin
                            r_out_data <= w_data[i];
                        end
                    end
                end

                assign w_valid[i+1]  = r_out_valid;
                assign w_data[i+1]   = r_out_data;
                assign w_ready[i]    = r_ready;
                assign w_cnt_nxt[i]  = {1'b0, w_out_nxt};
            end else begin : g_full
                logic                r_out_valid;
                logic                r_skid_valid;
                logic                r_ready;
                logic [c_BEAT_W-1:0] r_out_data;
                logic [c_BEAT_W-1:0] r_skid_data;
                logic                w_in_hs;
                logic                w_down_ready;
                logic                w_out_nxt;
                logic                w_skid_nxt;
                logic                w_load_out;
                logic                w_load_skid;
                logic                w_skid_to_out;

                assign w_down_ready = w_ready[i+1];
                assign w_in_hs      = w_valid[i] && r_ready;

                // r_ready is only high while the skid is empty, so an accepted
                // beat always has somewhere to go.
                always_comb begin
                    w_out_nxt     = r_out_valid;
                    w_skid_nxt    = r_skid_valid;
                    w_load_out    = 1'b0;
                    w_load_skid   = 1'b0;
                    w_skid_to_out = 1'b0;
                    if (w_in_hs) begin
                        if (w_down_ready || !r_out_valid) begin
                            w_out_nxt  = 1'b1;
                            w_load_out = 1'b1;
                        end else begin
                            w_skid_nxt  = 1'b1;
                            w_load_skid = 1'b1;
                        end
                    end else if (r_skid_valid && w_down_ready) begin
                        w_out_nxt     = 1'b1;
                        w_skid_nxt    = 1'b0;
                        w_skid_to_out = 1'b1;
                    end else if (r_out_valid && w_down_ready) begin
                        w_out_nxt = 1'b0;
                    end
                end

                // Registering !skid_next is the same function as
                // down_ready || (!skid_valid && (!out_valid || !up_valid))
                // evaluated on the current state, given that the skid only
                // fills while the output register is stalled.
                always_ff @(posedge aclk) begin
                    if (areset) begin
                        r_out_valid  <= 1'b0;
                        r_skid_valid <= 1'b0;
                        r_ready      <= 1'b0;
                        r_out_data   <= '0;
                        r_skid_data  <= '0;
                    end else begin
                        r_out_valid  <= w_out_nxt;
                        r_skid_valid <= w_skid_nxt;
                        r_ready      <= !w_skid_nxt;
                        if (w_load_out) begin
                            r_out_data <= w_data[i];
                        end else if (w_skid_to_out) begin
                            r_out_data <= r_skid_data;
                        end
                        if (w_load_skid) begin
                            r_skid_data <= w_data[i];
                        end
                    end
                end

                assign w_valid[i+1] = r_out_valid;
                assign w_data[i+1]  = r_out_data;
                assign w_ready[i]   = r_ready;
                assign w_cnt_nxt[i] = {1'b0, w_out_nxt} + {1'b0, w_skid_nxt};
            end
        end

        // Sum of next-state valid flags, so the registered count matches the
        // slice contents right after each edge.
        always_comb begin
            w_occ_nxt = '0;
            for (int k = 0; k < STAGES; k++) begin
                w_occ_nxt = w_occ_nxt + c_OCC_W'(w_cnt_nxt[k]);
            end
        end

        always_ff @(posedge aclk) begin
            if (areset) begin
                r_occ <= '0;
            end else begin
                r_occ <= w_occ_nxt;
            end
        end

        assign occupancy = r_occ;
    end

endmodule
`default_nettype wire

// File: tb/tb_axis_reg_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : tb_axis_reg_pipe
//  Description : Self-checking bench for axis_reg_pipe. Five instances:
//                0: mode 2, 2 stages   1: mode 2, 3 stages
//                2: mode 1, 1 stage    3: mode 2, 4 stages, ID/DEST/USER 4/3/8
//                4: mode 0 (bypass)
//                A queue per instance holds accepted beats; every cycle the
//                master side, occupancy, reset state and AXIS stability are
//                compared against it.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_axis_reg_pipe;

    logic clk;
    logic areset;

    logic [4:0]  sv, sl, mr;
    logic [31:0] sd   [5];
    logic [3:0]  sk   [5];
    logic [3:0]  sid  [5];
    logic [2:0]  sdst [5];
    logic [7:0]  sus  [5];

    wire  [4:0]  mv, ml, sr;
    wire  [31:0] md   [5];
    wire  [3:0]  mk   [5];
    wire  [3:0]  mid  [5];
    wire  [2:0]  mdst [5];
    wire  [7:0]  mus  [5];
    wire  [3:0]  occ  [5];
    wire  [51:0] mbeat [5];

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;

    logic [51:0] q [5][$];
    int n_in [5], n_out [5];
    int first_in_cyc [5], first_out_cyc [5], last_out_cyc [5];
    int gaps [5], max_occ [5], tlast_cnt [5], tlast_at [5];
    logic [31:0] last_out_data [5];
    logic [4:0]  hold;
    logic [51:0] hold_beat [5];
    logic rst_q  = 1'b0;
    logic rst_q2 = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT instances ----------------
    for (genvar k = 0; k < 5; k++) begin : g_dut
        if (k != 3) begin : g_plain
            localparam int ST = (k == 0) ? 2 : (k == 1) ? 3 : (k == 2) ? 1 : 2;
            localparam int MD = (k == 2) ? 1 : (k == 4) ? 0 : 2;
            wire [0:0] w_mid, w_mdst, w_mus;
            wire [$clog2(2*ST+1)-1:0] w_occ;
            axis_reg_pipe #(
                .DATA_BITS(32), .ID_BITS(0), .DEST_BITS(0), .USER_BITS(0),
                .STAGES(ST), .REG_MODE(MD)
            ) u_dut (
                .aclk(clk), .areset(areset),
                .s_axis_tvalid(sv[k]), .s_axis_tready(sr[k]),
                .s_axis_tdata(sd[k]), .s_axis_tkeep(sk[k]), .s_axis_tlast(sl[k]),
                .s_axis_tid(sid[k][0:0]), .s_axis_tdest(sdst[k][0:0]), .s_axis_tuser(sus[k][0:0]),
                .m_axis_tvalid(mv[k]), .m_axis_tready(mr[k]),
                .m_axis_tdata(md[k]), .m_axis_tkeep(mk[k]), .m_axis_tlast(ml[k]),
                .m_axis_tid(w_mid), .m_axis_tdest(w_mdst), .m_axis_tuser(w_mus),
                .occupancy(w_occ)
            );
            assign mid[k]  = {3'd0, w_mid};
            assign mdst[k] = {2'd0, w_mdst};
            assign mus[k]  = {7'd0, w_mus};
            assign occ[k]  = 4'(w_occ);
        end else begin : g_side
            axis_reg_pipe #(
                .DATA_BITS(32), .ID_BITS(4), .DEST_BITS(3), .USER_BITS(8),
                .STAGES(4), .REG_MODE(2)
            ) u_dut (
                .aclk(clk), .areset(areset),
                .s_axis_tvalid(sv[k]), .s_axis_tready(sr[k]),
                .s_axis_tdata(sd[k]), .s_axis_tkeep(sk[k]), .s_axis_tlast(sl[k]),
                .s_axis_tid(sid[k]), .s_axis_tdest(sdst[k]), .s_axis_tuser(sus[k]),
                .m_axis_tvalid(mv[k]), .m_axis_tready(mr[k]),
                .m_axis_tdata(md[k]), .m_axis_tkeep(mk[k]), .m_axis_tlast(ml[k]),
                .m_axis_tid(mid[k]), .m_axis_tdest(mdst[k]), .m_axis_tuser(mus[k]),
                .occupancy(occ[k])
            );
        end
        assign mbeat[k] = {md[k], mk[k], ml[k], mid[k], mdst[k], mus[k]};
    end

    // ---------------- helpers ----------------
    task automatic chk(input string name, input int k, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s[%0d] at cycle %0d: got 0x%0h, expected 0x%0h", name, k, cyc, act, exp);
        end
    endtask

    // Expected beat as seen at the master: absent sidebands read back as 0.
    function automatic logic [51:0] sbeat(input int k);
        logic [3:0] id;
        logic [2:0] de;
        logic [7:0] us;
        id = (k == 3) ? sid[k]  : 4'd0;
        de = (k == 3) ? sdst[k] : 3'd0;
        us = (k == 3) ? sus[k]  : 8'd0;
        return {sd[k], sk[k], sl[k], id, de, us};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic new_beat(input int k);
        sd[k]   = $urandom;
        sk[k]   = 4'($urandom);
        sl[k]   = 1'($urandom);
        sid[k]  = 4'($urandom);
        sdst[k] = 3'($urandom);
        sus[k]  = 8'($urandom);
    endtask

    task automatic reset_track(input int k);
        first_in_cyc[k]  = -1;
        first_out_cyc[k] = -1;
        last_out_cyc[k]  = -1;
        gaps[k]          = 0;
        max_occ[k]       = 0;
        tlast_cnt[k]     = 0;
        tlast_at[k]      = 0;
    endtask

    // ---------------- compare process ----------------
    initial begin
        logic [51:0] sb, mb, ex;
        forever begin
            @(negedge clk);
            cyc++;
            for (int k = 0; k < 5; k++) begin
                sb = sbeat(k);
                mb = mbeat[k];
                if (k == 4) begin
                    chk("bypass_valid", k, 64'(mv[4]), 64'(sv[4]));
                    chk("bypass_ready", k, 64'(sr[4]), 64'(mr[4]));
                    chk("bypass_beat",  k, 64'(mb), 64'(sb));
                    chk("bypass_occ",   k, 64'(occ[4]), 64'd0);
                end else if (rst_q) begin
                    chk("rst_valid", k, 64'(mv[k]), 64'd0);
                    chk("rst_ready", k, 64'(sr[k]), 64'd0);
                    chk("rst_beat",  k, 64'(mb), 64'd0);
                    chk("rst_occ",   k, 64'(occ[k]), 64'd0);
                end else begin
                    if (rst_q2) chk("ready_after_rst", k, 64'(sr[k]), 64'd1);
                    chk("occupancy", k, 64'(occ[k]), 64'(q[k].size()));
                    if (hold[k]) begin
                        chk("stable_valid", k, 64'(mv[k]), 64'd1);
                        chk("stable_beat",  k, 64'(mb), 64'(hold_beat[k]));
                    end
                end
                if (int'(occ[k]) > max_occ[k]) max_occ[k] = int'(occ[k]);
                if (!areset) begin
                    if (sv[k] && sr[k]) begin
                        q[k].push_back(sb);
                        n_in[k]++;
                        if (first_in_cyc[k] < 0) first_in_cyc[k] = cyc;
                    end
                    if (mv[k] && mr[k]) begin
                        n_out[k]++;
                        if (q[k].size() == 0) begin
                            n_checks++;
                            n_err++;
                            $display("FAIL unexpected_beat[%0d] at cycle %0d: got 0x%0h, expected no beat", k, cyc, mb);
                        end else begin
                            ex = q[k].pop_front();
                            chk("beat", k, 64'(mb), 64'(ex));
                        end
                        if (first_out_cyc[k] < 0) first_out_cyc[k] = cyc;
                        if (last_out_cyc[k] >= 0 && cyc - last_out_cyc[k] != 1) gaps[k]++;
                        last_out_cyc[k]  = cyc;
                        last_out_data[k] = md[k];
                        if (ml[k]) begin
                            tlast_cnt[k]++;
                            tlast_at[k] = n_out[k];
                        end
                    end
                end else begin
                    q[k].delete();
                end
                hold[k]      = !areset && (k != 4) && mv[k] && !mr[k];
                hold_beat[k] = mb;
            end
            rst_q2 = rst_q;
            rst_q  = areset;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    // ---------------- stimulus ----------------
    initial begin
        int bi, bo, prev;
        areset = 1'b1;
        sv = '0; sl = '0; mr = '1; hold = '0;
        for (int k = 0; k < 5; k++) begin
            sd[k] = '0; sk[k] = '0; sid[k] = '0; sdst[k] = '0; sus[k] = '0;
            n_in[k] = 0; n_out[k] = 0; last_out_data[k] = '0; hold_beat[k] = '0;
            reset_track(k);
        end
        repeat (3) tick();
        areset = 1'b0;
        repeat (3) tick();

        // A: mode 2, 2 stages, 16 back-to-back beats, sink always ready
        reset_track(0);
        bi = n_in[0]; bo = n_out[0];
        sd[0] = 32'd1; sk[0] = 4'hF; sv[0] = 1'b1;
        for (int c = 0; c < 80 && (n_out[0] - bo) < 16; c++) begin
            tick();
            if (n_in[0] - bi >= 16) sv[0] = 1'b0;
            else sd[0] = 32'(n_in[0] - bi + 1);
        end
        sv[0] = 1'b0;
        chk("A_latency", 0, 64'(first_out_cyc[0] - first_in_cyc[0]), 64'd2);
        chk("A_count",   0, 64'(n_out[0] - bo), 64'd16);
        chk("A_gaps",    0, 64'(gaps[0]), 64'd0);
        chk("A_peak_occ", 0, 64'(max_occ[0]), 64'd2);
        chk("A_last_data", 0, 64'(last_out_data[0]), 64'd16);

        // B: mode 2, 3 stages, sink stalled -> exactly 6 beats absorbed
        reset_track(1);
        bi = n_in[1]; bo = n_out[1];
        mr[1] = 1'b0; sd[1] = 32'd1; sv[1] = 1'b1;
        repeat (15) begin
            tick();
            sd[1] = 32'(n_in[1] - bi + 1);
        end
        @(negedge clk);
        chk("B_accepted", 1, 64'(n_in[1] - bi), 64'd6);
        chk("B_tready",   1, 64'(sr[1]), 64'd0);
        chk("B_occ_full", 1, 64'(occ[1]), 64'd6);
        tick();
        sv[1] = 1'b0; mr[1] = 1'b1;
        for (int c = 0; c < 40 && (n_out[1] - bo) < 6; c++) tick();
        chk("B_drained", 1, 64'(n_out[1] - bo), 64'd6);
        chk("B_last_data", 1, 64'(last_out_data[1]), 64'd6);

        // C: mode 1, 1 stage, 20 beats, tlast on the last one
        reset_track(2);
        bi = n_in[2]; bo = n_out[2];
        sd[2] = 32'd1; sk[2] = 4'h3; sl[2] = 1'b0; sv[2] = 1'b1;
        for (int c = 0; c < 100 && (n_out[2] - bo) < 20; c++) begin
            tick();
            if (n_in[2] - bi >= 20) sv[2] = 1'b0;
            else begin
                sd[2] = 32'(n_in[2] - bi + 1);
                sl[2] = (n_in[2] - bi + 1 == 20);
            end
        end
        sv[2] = 1'b0; sl[2] = 1'b0;
        chk("C_count",   2, 64'(n_out[2] - bo), 64'd20);
        chk("C_span",    2, 64'(last_out_cyc[2] - first_in_cyc[2]), 64'd39);
        chk("C_tlast_n", 2, 64'(tlast_cnt[2]), 64'd1);
        chk("C_tlast_at", 2, 64'(tlast_at[2] - bo), 64'd20);
        chk("C_last_data", 2, 64'(last_out_data[2]), 64'd20);

        // D: mode 2, 4 stages, sidebands, random valid/ready, 1000 beats
        reset_track(3);
        bi = n_in[3]; bo = n_out[3]; prev = n_in[3];
        new_beat(3);
        for (int c = 0; c < 8000 && (n_out[3] - bo) < 1000; c++) begin
            tick();
            if (n_in[3] != prev) begin
                prev = n_in[3];
                new_beat(3);
            end
            sv[3] = (n_in[3] - bi < 1000) ? 1'($urandom_range(0, 1)) : 1'b0;
            mr[3] = 1'($urandom_range(0, 1));
        end
        sv[3] = 1'b0; mr[3] = 1'b1;
        chk("D_count", 3, 64'(n_out[3] - bo), 64'd1000);
        tick();

        // Reset with 5 beats held in instance 3
        bi = n_in[3]; prev = n_in[3];
        mr[3] = 1'b0; new_beat(3); sv[3] = 1'b1;
        for (int c = 0; c < 30 && (n_in[3] - bi) < 5; c++) begin
            tick();
            if (n_in[3] != prev) begin
                prev = n_in[3];
                new_beat(3);
            end
        end
        sv[3] = 1'b0;
        @(negedge clk);
        chk("R_held", 3, 64'(occ[3]), 64'd5);
        tick();
        areset = 1'b1;
        tick();
        areset = 1'b0;
        @(negedge clk);
        chk("R_valid_cleared", 3, 64'(mv[3]), 64'd0);
        chk("R_occ_cleared",   3, 64'(occ[3]), 64'd0);
        @(negedge clk);
        chk("R_ready_back", 3, 64'(sr[3]), 64'd1);
        tick();
        bo = n_out[3];
        sd[3] = 32'h0000_0ABC; sk[3] = 4'h5; sl[3] = 1'b1;
        sid[3] = 4'h9; sdst[3] = 3'h2; sus[3] = 8'h5A;
        sv[3] = 1'b1; mr[3] = 1'b1; prev = n_in[3];
        for (int c = 0; c < 20 && (n_out[3] - bo) < 1; c++) begin
            tick();
            if (n_in[3] != prev) sv[3] = 1'b0;
        end
        sv[3] = 1'b0;
        chk("R_fresh_count", 3, 64'(n_out[3] - bo), 64'd1);
        chk("R_fresh_data",  3, 64'(last_out_data[3]), 64'h0ABC);

        // E: bypass, random traffic both sides
        for (int c = 0; c < 30; c++) begin
            tick();
            new_beat(4);
            sv[4] = 1'($urandom_range(0, 1));
            mr[4] = 1'($urandom_range(0, 1));
        end
        tick();
        sv[4] = 1'b0; mr[4] = 1'b1;
        repeat (3) tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
